matrix_mul: RTL and testbench

Fixed-point square-matrix multiplier. A host writes operand A, operand B and a Q-format word into an internal register file through a simple write port. Writing the format word starts a multiply. The block then streams the elements of (A·B)ᵀ one at a time, rescaled and saturated to the input word width. It sits behind a host loader that pushes words sequentially from a data file.

---
 rtl/matrix_mul_pkg.sv | 16 +
 rtl/fx_mac.sv | 49 ++++
 rtl/matrix_mul.sv | 157 +++++++++++++++
 tb/tb_matrix_mul.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mul_pkg.sv
// Shared constants and state encoding for the fixed-point matrix multiplier.
package matrix_mul_pkg;

  localparam int WORD_SIZE = 8;
  localparam int ADDRS_LEN = 6;
  localparam int N         = 4;
  localparam int FMT_ADDR  = 2 * N * N;
  localparam int ACC_W     = 2 * WORD_SIZE + $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

endpackage

// File: rtl/fx_mac.sv
// Signed multiply-accumulate with clear, plus arithmetic rescale and saturation
// of the running sum onto the element width.
module fx_mac #(
  parameter int WORD_SIZE = matrix_mul_pkg::WORD_SIZE,
  parameter int ACC_W     = matrix_mul_pkg::ACC_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [WORD_SIZE-1:0] a,
  input  logic signed [WORD_SIZE-1:0] b,
  input  logic        [3:0]           qf,
  output logic signed [WORD_SIZE-1:0] result
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WORD_SIZE - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic signed [ACC_W-1:0]       base, sum, scaled;

  // result reflects the sum including this cycle's product, so the element is
  // ready on the same edge as its final MAC.
  always_comb begin
    prod   = a * b;
    base   = clr ? '0 : acc_q;
    sum    = base + {{(ACC_W - 2 * WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
    acc_d  = en ? sum : acc_q;
    scaled = sum >>> qf;
    if (scaled > SAT_MAX) begin
      result = SAT_MAX[WORD_SIZE-1:0];
    end else if (scaled < SAT_MIN) begin
      result = SAT_MIN[WORD_SIZE-1:0];
    end else begin
      result = scaled[WORD_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mul.sv
// Square fixed-point matrix multiplier: host-loaded register file, one MAC per
// cycle, streams (A*B) transposed in row-major order.
module matrix_mul #(
  parameter int WORD_SIZE = matrix_mul_pkg::WORD_SIZE,
  parameter int ADDRS_LEN = matrix_mul_pkg::ADDRS_LEN,
  parameter int N         = matrix_mul_pkg::N
) (
  input  logic                        src_clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic        [WORD_SIZE-1:0] data_wr,
  input  logic        [ADDRS_LEN-1:0] addr,
  output logic signed [WORD_SIZE-1:0] AB_Transpose,
  output logic                        out_valid,
  output logic                        done,
  output logic        [3:0]           QI,
  output logic        [3:0]           QF
);

  import matrix_mul_pkg::*;

  localparam int NN      = N * N;
  localparam int FMT_SEL = 2 * NN;
  localparam int MAC_W   = 2 * WORD_SIZE + $clog2(N);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int EL_W    = (NN > 1) ? $clog2(NN) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_t                      state_q, state_d;
  logic signed [WORD_SIZE-1:0] a_q [NN];
  logic signed [WORD_SIZE-1:0] a_d [NN];
  logic signed [WORD_SIZE-1:0] b_q [NN];
  logic signed [WORD_SIZE-1:0] b_d [NN];
  logic        [IDX_W-1:0]     i_q, i_d, j_q, j_d, m_q, m_d;
  logic signed [WORD_SIZE-1:0] out_q, out_d;
  logic                        valid_q, valid_d;
  logic                        done_q, done_d;
  logic        [3:0]           qi_q, qi_d, qf_q, qf_d;

  logic                        mac_en, mac_clr;
  logic signed [WORD_SIZE-1:0] mac_a, mac_b, mac_res;
  int                          addr_i;

  function automatic logic [EL_W-1:0] el(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] c);
    return EL_W'(int'(r) * N + int'(c));
  endfunction

  always_comb begin
    mac_en  = (state_q == COMPUTE);
    mac_clr = (m_q == '0);
    mac_a   = a_q[el(i_q, m_q)];
    mac_b   = b_q[el(m_q, j_q)];
  end

  fx_mac #(
    .WORD_SIZE(WORD_SIZE),
    .ACC_W    (MAC_W)
  ) u_mac (
    .clk   (src_clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (mac_clr),
    .a     (mac_a),
    .b     (mac_b),
    .qf    (qf_q),
    .result(mac_res)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    m_d     = m_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = done_q;
    qi_d    = qi_q;
    qf_d    = qf_q;
    addr_i  = int'(addr);

    if (we && (state_q != COMPUTE)) begin
      if (addr_i < NN) begin
        a_d[EL_W'(addr_i)] = data_wr;
      end else if (addr_i < FMT_SEL) begin
        b_d[EL_W'(addr_i - NN)] = data_wr;
      end else if (addr_i == FMT_SEL) begin
        qi_d    = data_wr[7:4];
        qf_d    = data_wr[3:0];
        done_d  = 1'b0;
        i_d     = '0;
        j_d     = '0;
        m_d     = '0;
        state_d = COMPUTE;
      end
    end

    // i is the inner output index so elements emerge column by column.
    if (state_q == COMPUTE) begin
      m_d = m_q + 1'b1;
      if (m_q == IDX_LAST) begin
        m_d     = '0;
        out_d   = mac_res;
        valid_d = 1'b1;
        if (i_q == IDX_LAST) begin
          i_d = '0;
          if (j_q == IDX_LAST) begin
            j_d     = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      i_q     <= '0;
      j_q     <= '0;
      m_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      qi_q    <= '0;
      qf_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      m_q     <= m_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      qi_q    <= qi_d;
      qf_q    <= qf_d;
    end
  end

  assign AB_Transpose = out_q;
  assign out_valid    = valid_q;
  assign done         = done_q;
  assign QI           = qi_q;
  assign QF           = qf_q;

endmodule

// File: tb/tb_matrix_mul.sv
// Directed checks for matrix_mul: identity, saturation, truncation, write
// protection, reset during compute and restart from DONE.
module tb_matrix_mul;

  localparam int NN  = 16;
  localparam int FMT = 32;

  localparam logic [7:0] EXP_ID [NN] = '{
    8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31,
    8'h02, 8'h12, 8'h22, 8'h32, 8'h03, 8'h13, 8'h23, 8'h33};
  localparam logic [7:0] EXP_Q53 [NN] = '{
    8'h00, 8'h20, 8'h40, 8'h60, 8'h02, 8'h22, 8'h42, 8'h62,
    8'h04, 8'h24, 8'h44, 8'h64, 8'h06, 8'h26, 8'h46, 8'h66};

  logic              src_clk = 1'b0;
  logic              rst_n;
  logic              we;
  logic        [7:0] data_wr;
  logic        [5:0] addr;
  logic signed [7:0] ab_t;
  logic              out_valid;
  logic              done;
  logic        [3:0] qi, qf;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] ma [NN];
  logic [7:0] mb [NN];
  logic [7:0] cap_val [NN];
  int         cap_cyc [NN];
  int         cap_n;
  int         done_cyc;
  logic       done_first;

  matrix_mul #(.WORD_SIZE(8), .ADDRS_LEN(6), .N(4)) dut (
    .src_clk     (src_clk),
    .rst_n       (rst_n),
    .we          (we),
    .data_wr     (data_wr),
    .addr        (addr),
    .AB_Transpose(ab_t),
    .out_valid   (out_valid),
    .done        (done),
    .QI          (qi),
    .QF          (qf)
  );

  always #5 src_clk = ~src_clk;

  // Called at a falling edge; the write lands on the following rising edge.
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    we      = 1'b1;
    addr    = a;
    data_wr = d;
    @(negedge src_clk);
    we      = 1'b0;
  endtask

  task automatic load_mats();
    for (int k = 0; k < NN; k++) wr(6'(k), ma[k]);
    for (int k = 0; k < NN; k++) wr(6'(NN + k), mb[k]);
  endtask

  task automatic start(input logic [7:0] fmt);
    wr(6'(FMT), fmt);
  endtask

  // Records every out_valid pulse for 70 cycles after the start edge.
  task automatic capture();
    cap_n      = 0;
    done_cyc   = -1;
    done_first = 1'bx;
    for (int k = 0; k < NN; k++) begin
      cap_val[k] = 8'hxx;
      cap_cyc[k] = -1;
    end
    for (int n = 1; n <= 70; n++) begin
      @(negedge src_clk);
      if (n == 1) done_first = done;
      if (out_valid) begin
        if (cap_n < NN) begin
          cap_val[cap_n] = ab_t;
          cap_cyc[cap_n] = n;
        end
        cap_n++;
      end
      if (done && done_cyc < 0) done_cyc = n;
    end
  endtask

  task automatic fill(input logic [7:0] av, input logic [7:0] bv);
    for (int k = 0; k < NN; k++) begin
      ma[k] = av;
      mb[k] = bv;
    end
  endtask

  task automatic fill_identity();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        ma[r*4+c] = (r == c) ? 8'h10 : 8'h00;
        mb[r*4+c] = 8'(16 * r + c);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; addr = '0; data_wr = '0;
    repeat (2) @(negedge src_clk);
    vectors++; if (ab_t !== 8'h00) begin miscompares++; $display("FAIL reset_ab: got %h expected 00", ab_t); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (qi !== 4'h0) begin miscompares++; $display("FAIL reset_qi: got %h expected 0", qi); end
    vectors++; if (qf !== 4'h0) begin miscompares++; $display("FAIL reset_qf: got %h expected 0", qf); end
    rst_n = 1'b1;
    @(negedge src_clk);
  endtask

  task automatic test_identity();
    fill_identity();
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL id_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== EXP_ID[k]) begin miscompares++; $display("FAIL id_val[%0d]: got %h expected %h", k, cap_val[k], EXP_ID[k]); end
      vectors++; if (cap_cyc[k] !== 4 * (k + 1)) begin miscompares++; $display("FAIL id_cycle[%0d]: got %0d expected %0d", k, cap_cyc[k], 4 * (k + 1)); end
    end
    vectors++; if (done_cyc !== 64) begin miscompares++; $display("FAIL id_done_cycle: got %0d expected 64", done_cyc); end
    vectors++; if (qi !== 4'h4) begin miscompares++; $display("FAIL id_qi: got %h expected 4", qi); end
    vectors++; if (qf !== 4'h4) begin miscompares++; $display("FAIL id_qf: got %h expected 4", qf); end
  endtask

  task automatic test_write_protect();
    wr(6'd40, 8'h55);
    start(8'h44);
    fork
      capture();
      begin
        for (int k = 0; k < NN; k++) wr(6'(k), 8'h00);
      end
    join
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL wp_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== EXP_ID[k]) begin miscompares++; $display("FAIL wp_val[%0d]: got %h expected %h", k, cap_val[k], EXP_ID[k]); end
    end
    vectors++; if (done_cyc !== 64) begin miscompares++; $display("FAIL wp_done_cycle: got %0d expected 64", done_cyc); end
  endtask

  task automatic test_saturation();
    fill(8'h70, 8'h70);
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL satp_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== 8'h7F) begin miscompares++; $display("FAIL satp_val[%0d]: got %h expected 7f", k, cap_val[k]); end
    end
    fill(8'h70, 8'h90);
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL satn_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== 8'h80) begin miscompares++; $display("FAIL satn_val[%0d]: got %h expected 80", k, cap_val[k]); end
    end
  endtask

  task automatic test_negative();
    fill(8'hF0, 8'h10);
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL neg_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== 8'hC0) begin miscompares++; $display("FAIL neg_val[%0d]: got %h expected c0", k, cap_val[k]); end
    end
  endtask

  task automatic test_truncation();
    fill(8'h00, 8'h00);
    ma[0] = 8'h01;
    mb[0] = 8'hFF;
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_val[0] !== 8'hFF) begin miscompares++; $display("FAIL trunc_neg_first: got %h expected ff", cap_val[0]); end
    for (int k = 1; k < NN; k++) begin
      vectors++; if (cap_val[k] !== 8'h00) begin miscompares++; $display("FAIL trunc_neg_rest[%0d]: got %h expected 00", k, cap_val[k]); end
    end
    wr(6'(NN), 8'h01);
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL trunc_pos_count: got %0d expected %0d", cap_n, NN); end
    vectors++; if (cap_val[0] !== 8'h00) begin miscompares++; $display("FAIL trunc_pos_first: got %h expected 00", cap_val[0]); end
  endtask

  task automatic test_reset_mid_compute();
    int pulses;
    int done_seen;
    fill_identity();
    load_mats();
    start(8'h44);
    repeat (20) @(negedge src_clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (ab_t !== 8'h00) begin miscompares++; $display("FAIL mid_rst_ab: got %h expected 00", ab_t); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %b expected 0", done); end
    vectors++; if ({qi, qf} !== 8'h00) begin miscompares++; $display("FAIL mid_rst_fmt: got %h expected 00", {qi, qf}); end
    @(negedge src_clk);
    rst_n = 1'b1;
    pulses    = 0;
    done_seen = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge src_clk);
      if (out_valid) pulses++;
      if (done) done_seen++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mid_rst_no_valid: got %0d pulses expected 0", pulses); end
    vectors++; if (done_seen !== 0) begin miscompares++; $display("FAIL mid_rst_no_done: got %0d cycles expected 0", done_seen); end
    load_mats();
    start(8'h44);
    capture();
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL reload_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== EXP_ID[k]) begin miscompares++; $display("FAIL reload_val[%0d]: got %h expected %h", k, cap_val[k], EXP_ID[k]); end
    end
  endtask

  task automatic test_restart_done();
    start(8'h53);
    capture();
    vectors++; if (done_first !== 1'b0) begin miscompares++; $display("FAIL rs_done_cleared: got %b expected 0", done_first); end
    vectors++; if (cap_n !== NN) begin miscompares++; $display("FAIL rs_count: got %0d expected %0d", cap_n, NN); end
    for (int k = 0; k < NN; k++) begin
      vectors++; if (cap_val[k] !== EXP_Q53[k]) begin miscompares++; $display("FAIL rs_val[%0d]: got %h expected %h", k, cap_val[k], EXP_Q53[k]); end
      vectors++; if (cap_cyc[k] !== 4 * (k + 1)) begin miscompares++; $display("FAIL rs_cycle[%0d]: got %0d expected %0d", k, cap_cyc[k], 4 * (k + 1)); end
    end
    vectors++; if (done_cyc !== 64) begin miscompares++; $display("FAIL rs_done_cycle: got %0d expected 64", done_cyc); end
    vectors++; if (qi !== 4'h5) begin miscompares++; $display("FAIL rs_qi: got %h expected 5", qi); end
    vectors++; if (qf !== 4'h3) begin miscompares++; $display("FAIL rs_qf: got %h expected 3", qf); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_write_protect();
    test_saturation();
    test_negative();
    test_truncation();
    test_reset_mid_compute();
    test_restart_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
